// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the lane FIFO controller and the
// lane flow-control logic that reuses the same pause/continue thresholds.
package fifo_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_MAIN_SIZE = 6;
    localparam int DEF_DEPTH     = 2 ** DEF_MAIN_SIZE;
    localparam int DEF_AF_THRESH = 60;
    localparam int DEF_AE_THRESH = 4;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2,
        ST_ERROR  = 2'd3
    } fifo_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping memory address register: advances by one on each enabled edge,
// rolling over from 2**WIDTH-1 to 0 with no special handling.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_MAIN_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_6x8.sv
// Pointer/flag controller for a first-word fall-through lane FIFO. Data lives
// in the external memory; this block only decides which requests are accepted.
module fifo_ctrl_6x8
    import fifo_pkg::*;
#(
    parameter int MAIN_SIZE = DEF_MAIN_SIZE,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 write,
    output logic                 read,
    output logic [MAIN_SIZE-1:0] wr_ptr,
    output logic [MAIN_SIZE-1:0] rd_ptr,
    output logic [MAIN_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic [1:0]           dbg_state
);

    localparam int                 DEPTH    = 2 ** MAIN_SIZE;
    localparam logic [MAIN_SIZE:0] CNT_FULL = (MAIN_SIZE + 1)'(DEPTH);
    localparam logic [MAIN_SIZE:0] CNT_AF   = (MAIN_SIZE + 1)'(AF_THRESH);
    localparam logic [MAIN_SIZE:0] CNT_AE   = (MAIN_SIZE + 1)'(AE_THRESH);

    fifo_state_t        r_state;
    fifo_state_t        w_state_next;
    logic [MAIN_SIZE:0] r_count;
    logic [MAIN_SIZE:0] w_count_next;
    logic               w_write;
    logic               w_read;
    logic               w_overflow;
    logic               w_underflow;

    // A pop in FULL frees the slot the simultaneous push lands in, so the
    // push is still accepted; ERROR blocks everything until reset.
    always_comb begin
        w_write     = push && (r_state != ST_FULL || pop) && (r_state != ST_ERROR);
        w_read      = pop && (r_state != ST_EMPTY) && (r_state != ST_ERROR);
        w_overflow  = (r_state == ST_FULL) && push && !pop;
        w_underflow = (r_state == ST_EMPTY) && pop && !push;
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_write, w_read})
            2'b10:   w_count_next = r_count + (MAIN_SIZE + 1)'(1);
            2'b01:   w_count_next = r_count - (MAIN_SIZE + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_underflow) begin
                    w_state_next = ST_ERROR;
                end else if (w_write) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_count_next == '0) begin
                    w_state_next = ST_EMPTY;
                end else if (w_count_next == CNT_FULL) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_overflow) begin
                    w_state_next = ST_ERROR;
                end else if (w_count_next != CNT_FULL) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ERROR: w_state_next = ST_ERROR;
            default:  w_state_next = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    fifo_ptr #(.WIDTH(MAIN_SIZE)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_write),
        .o_ptr (wr_ptr)
    );

    fifo_ptr #(.WIDTH(MAIN_SIZE)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_read),
        .o_ptr (rd_ptr)
    );

    // Flags come straight off the registered count so they move with it.
    assign write        = w_write;
    assign read         = w_read;
    assign count        = r_count;
    assign full         = (r_count == CNT_FULL);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CNT_AF);
    assign almost_empty = (r_count <= CNT_AE);
    assign error        = (r_state == ST_ERROR);
    assign dbg_state    = r_state;

    a_full_empty_excl : assert property (@(posedge clk) disable iff (reset) !(full && empty));
    a_count_range     : assert property (@(posedge clk) disable iff (reset) count <= CNT_FULL);
    a_ptr_distance    : assert property (@(posedge clk) disable iff (reset)
                                         (wr_ptr - rd_ptr) == count[MAIN_SIZE-1:0]);
    a_error_sticky    : assert property (@(posedge clk) disable iff (reset) error |=> error);

endmodule

// File: tb/tb_fifo_ctrl_6x8.sv
// Bench for fifo_ctrl_6x8: a queue-based occupancy model plus a small memory
// model so head data can be checked in order through wrap-around.
module tb_fifo_ctrl_6x8;
    import fifo_pkg::*;

    localparam int DEPTH = DEF_DEPTH;
    localparam int DW    = DEF_DATA_SIZE;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     push = 1'b0;
    logic                     pop = 1'b0;
    logic [DW-1:0]            data_in = '0;
    logic                     write, read;
    logic [DEF_MAIN_SIZE-1:0] wr_ptr, rd_ptr;
    logic [DEF_MAIN_SIZE:0]   count;
    logic                     full, empty, almost_full, almost_empty, error;
    logic [1:0]               dbg_state;

    always #5 clk = ~clk;

    fifo_ctrl_6x8 dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .write        (write),
        .read         (read),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .dbg_state    (dbg_state)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[0:DEPTH-1];
    logic [DW-1:0] mon_exp;

    // Reference model: occupancy, lifetime accept totals and a sticky error bit.
    int m_count;
    int m_wr_total;
    int m_rd_total;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count    = 0;
        m_wr_total = 0;
        m_rd_total = 0;
        m_err      = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input bit ew, input bit er);
        chk("write",        write,        ew);
        chk("read",         read,         er);
        chk("count",        count,        m_count);
        chk("full",         full,         m_count == DEPTH);
        chk("empty",        empty,        m_count == 0);
        chk("almost_full",  almost_full,  m_count >= DEF_AF_THRESH);
        chk("almost_empty", almost_empty, m_count <= DEF_AE_THRESH);
        chk("error",        error,        m_err);
        chk("wr_ptr",       wr_ptr,       m_wr_total % DEPTH);
        chk("rd_ptr",       rd_ptr,       m_rd_total % DEPTH);
    endtask

    // Asserts reset wherever the caller currently is and checks outputs
    // before any clock edge arrives.
    task automatic apply_reset();
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic drive_cycle(input bit p, input bit q, input logic [DW-1:0] d);
        bit ew, er, ovf, unf;
        push    = p;
        pop     = q;
        data_in = d;
        ew  = !m_err && p && (m_count < DEPTH || q);
        er  = !m_err && q && (m_count > 0);
        ovf = !m_err && p && !q && (m_count == DEPTH);
        unf = !m_err && q && !p && (m_count == 0);
        if (ew) exp_q.push_back(d);
        @(negedge clk);
        check_outputs(ew, er);
        m_count    = m_count + int'(ew) - int'(er);
        m_wr_total = m_wr_total + int'(ew);
        m_rd_total = m_rd_total + int'(er);
        if (ovf || unf) m_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: the head is consumed before a same-cycle write lands, as in the
    // real memory, which matters for push+pop while full (wr_ptr == rd_ptr).
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (read) begin
                if (exp_q.size() == 0) begin
                    chk("head_unexpected_read", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("head_data", mem[rd_ptr], mon_exp);
                end
            end
            if (write) mem[wr_ptr] = data_in;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        apply_reset();
        repeat (5) drive_cycle(1'b0, 1'b0, '0);

        // Fill with an ascending pattern, hold full, then drain in order.
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, DW'(i));
        drive_cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, '0);
        drive_cycle(1'b0, 1'b0, '0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, DW'($urandom));
        repeat (3) drive_cycle(1'b1, 1'b1, DW'($urandom));
        drive_cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, '0);

        // Underflow then a push that must be refused.
        drive_cycle(1'b0, 1'b1, '0);
        drive_cycle(1'b0, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, 8'h55);
        drive_cycle(1'b1, 1'b1, 8'hAA);
        drive_cycle(1'b0, 1'b0, '0);
        apply_reset();

        // Fill to 10, drain to 3, then reset mid-cycle.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, '0);
        chk("mid_rd_ptr", rd_ptr, 32'd7);
        chk("mid_wr_ptr", wr_ptr, 32'd10);
        #2;
        apply_reset();
        drive_cycle(1'b0, 1'b0, '0);

        // Overflow from full.
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, DW'($urandom));
        drive_cycle(1'b1, 1'b0, 8'h77);
        drive_cycle(1'b0, 1'b1, '0);
        apply_reset();

        // Interleaved push/pop around occupancy 0..1 so both pointers wrap.
        for (int i = 0; i < 200; i++) begin
            if (m_count == 0) drive_cycle(1'b1, 1'($urandom_range(0, 1)), DW'($urandom));
            else if ($urandom_range(0, 1) == 0) drive_cycle(1'b0, 1'b1, '0);
            else drive_cycle(1'b1, 1'b1, DW'($urandom));
        end
        chk("wrap_pointer_total", 32'(m_wr_total > DEPTH), 32'd1);

        // Random traffic with shifting push bias; recover from any error.
        for (int i = 0; i < 800; i++) begin
            int pct;
            pct = ((i / 200) % 2 == 0) ? 70 : 35;
            drive_cycle(1'($urandom_range(0, 99) < pct), 1'($urandom_range(0, 99) < 50),
                        DW'($urandom));
            if (m_err) begin
                drive_cycle(1'b0, 1'b0, '0);
                apply_reset();
            end
        end
        drive_cycle(1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
